// File: rtl/cellrv32_xirq_filter_pkg.sv
// Shared constants and types for the XIRQ input filter: bus map and CTRL register layout.
package cellrv32_package;

  localparam logic [31:0] xirqf_base_c        = 32'hFFFFF700;
  localparam int unsigned xirqf_size_c        = 16;
  localparam logic [31:0] xirqf_ctrl_addr_c   = xirqf_base_c + 32'h0;
  localparam logic [31:0] xirqf_thresh_addr_c = xirqf_base_c + 32'h4;
  localparam logic [31:0] xirqf_level_addr_c  = xirqf_base_c + 32'h8;
  localparam logic [31:0] xirqf_change_addr_c = xirqf_base_c + 32'hC;

  // Prescaler counter must cover the largest period 2^7.
  localparam int unsigned xirqf_psc_w_c = 7;

  typedef struct packed {
    logic [2:0] psc;
    logic       en;
  } xirqf_ctrl_t;

endpackage

// File: rtl/cellrv32_xirq_filter_if.sv
// Register bus between the CPU IO space and the XIRQ input filter.
interface cellrv32_xirq_filter_if;
  logic [31:0] addr_i;
  logic        rden_i;
  logic        wren_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (output addr_i, rden_i, wren_i, data_i, input data_o, ack_o);
  modport slave  (input addr_i, rden_i, wren_i, data_i, output data_o, ack_o);
endinterface

// File: rtl/cellrv32_xirq_filter_ch.sv
// One filter channel: 2-FF synchronizer, debounce counter and filtered level.
module cellrv32_xirq_filter_ch #(
  parameter int unsigned CNT_W   = 8,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] thresh_i,
  input  logic             raw_i,
  output logic             filt_o,
  output logic             toggle_c
);

  logic             s1_q, s2_q, filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Debounce: a mismatch must persist for thresh_i ticks before the level follows.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (!en_i) begin
      filt_d = s2_q;
      cnt_d  = '0;
    end else if (clr_i || (s2_q == filt_q)) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == (thresh_i - CNT_W'(1))) begin
        filt_d = s2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      filt_q <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o   = filt_q;
  assign toggle_c = filt_d ^ filt_q;

endmodule

// File: rtl/cellrv32_xirq_filter.sv
// XIRQ input conditioner: bus registers, shared prescaler and per-channel debounce filters.
// Optional sticky CHANGE register is built when XIRQ_FILTER_CHANGE_EN is defined.
module cellrv32_xirq_filter
  import cellrv32_package::*;
#(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned CNT_W        = 8,
  parameter logic [31:0] FILT_RST_VAL = '0
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  cellrv32_xirq_filter_if.slave        bus,
  input  logic [31:0]                  xirq_raw_i,
  output logic [31:0]                  xirq_o
);

  xirqf_ctrl_t               ctrl_q;
  logic [CNT_W-1:0]          thresh_q;
  logic [xirqf_psc_w_c-1:0]  psc_cnt_q;
  logic [xirqf_psc_w_c-1:0]  psc_mask_c;
  logic [31:0]               data_q;
  logic                      ack_q;
  logic [31:0]               rdata_c;
  logic [31:0]               change_rd_c;
  logic [NUM_CH-1:0]         filt;
  logic [NUM_CH-1:0]         toggle;
  logic                      acc_en_c, wr_c, cfg_wr_c, tick_c;
  logic [1:0]                sel_c;
  logic                      unused_c;

  assign acc_en_c = (bus.addr_i[31:4] == xirqf_base_c[31:4]);
  assign sel_c    = bus.addr_i[3:2];
  assign wr_c     = acc_en_c & bus.wren_i;
  assign cfg_wr_c = wr_c & ((sel_c == 2'd0) | (sel_c == 2'd1));

  // Tick once every 2^PSC clocks; PSC=0 gives an all-zero mask, i.e. every clock.
  assign psc_mask_c = (xirqf_psc_w_c'(1) << ctrl_q.psc) - xirqf_psc_w_c'(1);
  assign tick_c     = ((psc_cnt_q & psc_mask_c) == psc_mask_c);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cellrv32_xirq_filter_ch #(
      .CNT_W   (CNT_W),
      .RST_VAL (FILT_RST_VAL[i])
    ) u_ch (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .en_i     (ctrl_q.en),
      .tick_i   (tick_c),
      .clr_i    (cfg_wr_c),
      .thresh_i (thresh_q),
      .raw_i    (xirq_raw_i[i]),
      .filt_o   (filt[i]),
      .toggle_c (toggle[i])
    );
  end

  assign xirq_o = 32'(filt);

`ifdef XIRQ_FILTER_CHANGE_EN
  logic [NUM_CH-1:0] change_q;
  logic [NUM_CH-1:0] change_clr_c;

  assign change_clr_c = (wr_c && (sel_c == 2'd3)) ? bus.data_i[NUM_CH-1:0] : '0;

  // New toggles win over a simultaneous write-one-to-clear.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) change_q <= '0;
    else         change_q <= (change_q & ~change_clr_c) | toggle;
  end

  assign change_rd_c = 32'(change_q);
`else
  assign change_rd_c = '0;
`endif

  always_comb begin
    rdata_c = '0;
    if (acc_en_c) begin
      case (sel_c)
        2'd0:    rdata_c = 32'(ctrl_q);
        2'd1:    rdata_c = 32'(thresh_q);
        2'd2:    rdata_c = xirq_o;
        default: rdata_c = change_rd_c;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ctrl_q    <= '0;
      thresh_q  <= CNT_W'(1);
      psc_cnt_q <= '0;
      data_q    <= '0;
      ack_q     <= 1'b0;
    end else begin
      ack_q     <= acc_en_c & (bus.rden_i | bus.wren_i);
      psc_cnt_q <= cfg_wr_c ? '0 : psc_cnt_q + xirqf_psc_w_c'(1);
      if (bus.rden_i) data_q <= rdata_c;
      if (wr_c && (sel_c == 2'd0)) ctrl_q <= xirqf_ctrl_t'(bus.data_i[3:0]);
      // A zero threshold would underflow the compare; store the minimum instead.
      if (wr_c && (sel_c == 2'd1))
        thresh_q <= (bus.data_i[CNT_W-1:0] == '0) ? CNT_W'(1) : bus.data_i[CNT_W-1:0];
    end
  end

  assign bus.data_o = data_q;
  assign bus.ack_o  = ack_q;

  assign unused_c = ^{bus.addr_i[1:0], bus.data_i, toggle};

endmodule

// File: tb/tb_cellrv32_xirq_filter.sv
// Directed self-checking bench for cellrv32_xirq_filter (NUM_CH=8, CNT_W=8, FILT_RST_VAL=1).
module tb_cellrv32_xirq_filter;
  import cellrv32_package::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] raw;
  logic [31:0] xirq;
  logic [31:0] rd;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat;

  cellrv32_xirq_filter_if bus ();

  cellrv32_xirq_filter #(
    .NUM_CH       (8),
    .CNT_W        (8),
    .FILT_RST_VAL (32'h1)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .bus        (bus),
    .xirq_raw_i (raw),
    .xirq_o     (xirq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr_i = a;
    bus.data_i = d;
    bus.wren_i = 1'b1;
    step(1);
    bus.wren_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr_i = a;
    bus.rden_i = 1'b1;
    step(1);
    bus.rden_i = 1'b0;
    d = bus.data_o;
  endtask

  initial begin
    rstn       = 1'b0;
    raw        = '0;
    bus.addr_i = '0;
    bus.data_i = '0;
    bus.rden_i = 1'b0;
    bus.wren_i = 1'b0;
    step(2);

    // Reset state and bypass latency
    check("rst_xirq", xirq, 32'h1);
    check("rst_data", bus.data_o, 32'h0);
    check("rst_ack", {31'b0, bus.ack_o}, 32'h0);
    rstn = 1'b1;
    step(2);
    check("byp_hold_2clk", xirq, 32'h1);
    step(1);
    check("byp_fall_3clk", xirq, 32'h0);
    bus_read(xirqf_ctrl_addr_c, rd);
    check("rst_ctrl", rd, 32'h0);
    bus_read(xirqf_thresh_addr_c, rd);
    check("rst_thresh", rd, 32'h1);

    // EN=1 PSC=0 THRESH=4: 3-clk pulse rejected, step passes after 6 clk
    bus_write(xirqf_ctrl_addr_c, 32'h1);
    check("wr_ack", {31'b0, bus.ack_o}, 32'h1);
    bus_write(xirqf_thresh_addr_c, 32'h4);
    step(2);
    raw[0] = 1'b1;
    step(3);
    raw[0] = 1'b0;
    step(10);
    check("glitch_rejected", xirq, 32'h0);
    raw[0] = 1'b1;
    step(5);
    check("deb_5clk_low", xirq, 32'h0);
    step(1);
    check("deb_6clk_high", xirq, 32'h1);

    // EN=1 PSC=2 THRESH=2: ticks every 4 clk after the THRESH write (W+4, W+8, W+12);
    // raw rises after W+2, so s2 mismatches from W+5 and filt flips at W+12 = 10 clk after the step
    bus_write(xirqf_ctrl_addr_c, 32'h5);
    bus_write(xirqf_thresh_addr_c, 32'h2);
    step(2);
    raw[1] = 1'b1;
    lat = 41;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (xirq[1]) begin
        lat = i;
        break;
      end
    end
    check("psc_latency", 32'(lat), 32'd10);
    bus_read(xirqf_level_addr_c, rd);
    check("level_read", rd, 32'h3);

    // THRESH 0 stores 1; mid-count THRESH write restarts the count
    bus_write(xirqf_thresh_addr_c, 32'h0);
    bus_read(xirqf_thresh_addr_c, rd);
    check("thresh_zero", rd, 32'h1);
    bus_write(xirqf_ctrl_addr_c, 32'h1);
    bus_write(xirqf_thresh_addr_c, 32'h4);
    step(2);
    raw[2] = 1'b1;
    step(4);
    bus_write(xirqf_thresh_addr_c, 32'h4);
    step(3);
    check("restart_no_early", xirq, 32'h3);
    step(1);
    check("restart_rise", xirq, 32'h7);

`ifdef XIRQ_FILTER_CHANGE_EN
    // Sticky CHANGE with W1C; a toggle in the clear cycle keeps the bit set
    bus_write(xirqf_ctrl_addr_c, 32'h0);
    bus_write(xirqf_change_addr_c, 32'hFFFF_FFFF);
    bus_read(xirqf_change_addr_c, rd);
    check("chg_cleared", rd, 32'h0);
    raw[3] = 1'b1;
    step(4);
    bus_read(xirqf_change_addr_c, rd);
    check("chg_set_ch3", rd, 32'h8);
    raw[3] = 1'b0;
    step(2);
    bus_write(xirqf_change_addr_c, 32'h8);
    bus_read(xirqf_change_addr_c, rd);
    check("chg_set_wins", rd, 32'h8);
    bus_write(xirqf_change_addr_c, 32'h8);
    bus_read(xirqf_change_addr_c, rd);
    check("chg_w1c", rd, 32'h0);
`else
    bus_write(xirqf_change_addr_c, 32'hFF);
    bus_read(xirqf_change_addr_c, rd);
    check("chg_absent", rd, 32'h0);
`endif

    // Out-of-window read: no ack, data 0
    bus_read(xirqf_level_addr_c, rd);
    check("level_pre_unmapped", rd, 32'h7);
    bus_read(xirqf_base_c + 32'h10, rd);
    check("unmapped_data", rd, 32'h0);
    check("unmapped_ack", {31'b0, bus.ack_o}, 32'h0);

    // Reset mid-debounce with a read in flight
    bus_write(xirqf_ctrl_addr_c, 32'h1);
    bus_write(xirqf_thresh_addr_c, 32'h4);
    raw[4] = 1'b1;
    raw[9] = 1'b1;
    step(4);
    check("mid_debounce", xirq, 32'h7);
    rstn       = 1'b0;
    bus.addr_i = xirqf_level_addr_c;
    bus.rden_i = 1'b1;
    step(1);
    bus.rden_i = 1'b0;
    check("midrst_xirq", xirq, 32'h1);
    check("midrst_ack", {31'b0, bus.ack_o}, 32'h0);
    check("midrst_data", bus.data_o, 32'h0);
    rstn = 1'b1;
    bus_read(xirqf_ctrl_addr_c, rd);
    check("midrst_ctrl", rd, 32'h0);
    bus_read(xirqf_thresh_addr_c, rd);
    check("midrst_thresh", rd, 32'h1);
    step(2);
    check("bypass_mask_hi", xirq, 32'h17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
